// File: rtl/instr_fetch.sv
// instr_fetch: single-outstanding instruction fetch unit.
//
// Reads one 32-bit instruction at a time from instruction memory, presents it
// to decode, and computes the next PC for an external PC register that loads
// pc_d every cycle.
//
// Ports
//   clk, rst              clock, asynchronous active-high reset
//   pc_q / pc_d           current PC in, next PC out (external register)
//   imem_req/imem_addr    read request and address (pc_q)
//   imem_ready            memory accepts the request this cycle
//   imem_rvalid/rdata     read response
//   instr/instr_pc/       fetched word, its address, and valid flag
//   instr_valid
//   dec_ready             decode consumes instr this cycle
//   branch_taken/target   next-PC override, only when a consume happens
//   redirect_valid/pc     flush/exception redirect, highest priority
//   fetch_err             sticky error (misaligned PC or response timeout)
//   state_dbg             current FSM state: 0 IDLE, 1 REQ, 2 WAIT, 3 HOLD, 4 ERR
//
// Handshakes: a memory request transfers on a cycle where imem_req and
// imem_ready are both 1; imem_req/imem_addr stay stable until then unless a
// redirect withdraws the request. An instruction transfers to decode on a
// cycle where instr_valid and dec_ready are both 1.
module instr_fetch #(
  parameter int unsigned TIMEOUT = 255,
  parameter logic [63:0] PC_STEP = 64'd4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pc_q,
  output logic [63:0] pc_d,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr,
  output logic [63:0] instr_pc,
  output logic        instr_valid,
  input  logic        dec_ready,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        fetch_err,
  output logic [2:0]  state_dbg
);

  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  localparam logic [CW:0] TIMEOUT_W = (CW + 1)'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e        state_q;
  logic          flush_q;      // response of the in-flight read must be dropped
  logic [CW-1:0] wait_cnt_q;
  logic [31:0]   instr_q;
  logic [63:0]   instr_pc_q;
  logic          instr_valid_q;
  logic          fetch_err_q;

  logic          misaligned;
  logic          consume;
  logic [CW:0]   cnt_inc;

  assign misaligned = (pc_q[1:0] != 2'b00);
  assign consume    = (state_q == S_HOLD) && dec_ready;
  assign cnt_inc    = {1'b0, wait_cnt_q} + (CW + 1)'(1);

  // A redirect or a misaligned PC suppresses the request in the same cycle,
  // so memory never accepts a request the FSM is about to abandon.
  assign imem_req  = (state_q == S_REQ) && !redirect_valid && !misaligned;
  assign imem_addr = pc_q;

  always_comb begin
    pc_d = pc_q;
    if (!rst && state_q != S_ERR) begin
      if (redirect_valid) begin
        pc_d = redirect_pc;
      end else if (consume) begin
        pc_d = branch_taken ? branch_target : pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      flush_q       <= 1'b0;
      wait_cnt_q    <= '0;
      instr_q       <= '0;
      instr_pc_q    <= '0;
      instr_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: state_q <= S_REQ;
        S_REQ: begin
          if (redirect_valid) begin
            state_q <= S_REQ;
          end else if (misaligned) begin
            state_q     <= S_ERR;
            fetch_err_q <= 1'b1;
          end else if (imem_ready) begin
            state_q    <= S_WAIT;
            wait_cnt_q <= '0;
            flush_q    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (flush_q || redirect_valid) begin
              flush_q <= 1'b0;
              state_q <= S_REQ;
            end else begin
              instr_q       <= imem_rdata;
              instr_pc_q    <= pc_q;
              instr_valid_q <= 1'b1;
              state_q       <= S_HOLD;
            end
          end else begin
            // Saturate so a redirect held across the limit cannot wrap the count.
            if (cnt_inc < TIMEOUT_W) wait_cnt_q <= cnt_inc[CW-1:0];
            if (redirect_valid) begin
              flush_q <= 1'b1;
            end else if (cnt_inc >= TIMEOUT_W) begin
              state_q     <= S_ERR;
              fetch_err_q <= 1'b1;
            end
          end
        end
        S_HOLD: begin
          if (redirect_valid || dec_ready) begin
            instr_valid_q <= 1'b0;
            state_q       <= S_REQ;
          end
        end
        S_ERR:   state_q <= S_ERR;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = instr_valid_q;
  assign fetch_err   = fetch_err_q;
  assign state_dbg   = state_q;

endmodule
